// File: rtl/ntt_stream_ctrl.sv
// Streaming front-end for an NTT core: assembles input rows into host memory,
// launches the transform, then reads rows back and streams them out lane by lane.
module ntt_stream_ctrl #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 257,
  parameter int ROWS   = 16,
  parameter int RD_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_start,
  input  logic [5:0]              cfg_mod_idx,
  output logic                    busy,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [WIDTH-1:0]        m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    ntt_start,
  output logic [5:0]              ntt_mod_idx,
  output logic                    ntt_mem_write,
  output logic                    ntt_mem_read,
  output logic [8*SIZE-1:0]       ntt_mem_addr,
  output logic [WIDTH*SIZE-1:0]   ntt_din,
  input  logic [WIDTH*SIZE-1:0]   ntt_dout,
  input  logic                    ntt_done,
  output logic                    done
);

  localparam int LW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] READ  = 3'd5;
  localparam logic [2:0] DRAIN = 3'd6;
  localparam logic [2:0] FIN   = 3'd7;

  localparam logic [LW-1:0] LANE_LAST = LW'(SIZE - 1);
  localparam logic [7:0]    ROW_LAST  = 8'(ROWS - 1);
  localparam logic [7:0]    LAT_LAST  = 8'(RD_LAT);

  logic [2:0]            state_q, state_d;
  logic [LW-1:0]         lane_q,  lane_d;
  logic [7:0]            row_q,   row_d;
  logic [7:0]            lat_q,   lat_d;
  logic [5:0]            mod_q,   mod_d;
  logic [WIDTH*SIZE-1:0] din_q,   din_d;
  logic [WIDTH*SIZE-1:0] cap_q,   cap_d;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    row_d   = row_q;
    lat_d   = lat_q;
    mod_d   = mod_q;
    din_d   = din_q;
    cap_d   = cap_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          mod_d   = cfg_mod_idx;
          lane_d  = '0;
          row_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (s_valid) begin
          din_d[lane_q*WIDTH +: WIDTH] = s_data;
          if (lane_q == LANE_LAST) begin
            lane_d  = '0;
            state_d = WRITE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      WRITE: begin
        row_d   = row_q + 8'd1;
        state_d = (row_q == ROW_LAST) ? RUN : LOAD;
      end
      RUN: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      // lat_q doubles as the "first WAIT cycle seen" flag so a stale ntt_done is ignored
      WAIT: begin
        if (lat_q == '0) begin
          lat_d = 8'd1;
        end else if (ntt_done) begin
          lat_d   = '0;
          row_d   = '0;
          state_d = READ;
        end
      end
      // Strobe goes out while lat_q==0; data is taken RD_LAT cycles later
      READ: begin
        if (lat_q == LAT_LAST) begin
          cap_d   = ntt_dout;
          lat_d   = '0;
          lane_d  = '0;
          state_d = DRAIN;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      DRAIN: begin
        if (m_ready) begin
          if (lane_q == LANE_LAST) begin
            lane_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = FIN;
            end else begin
              row_d   = row_q + 8'd1;
              state_d = READ;
            end
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      row_q   <= '0;
      lat_q   <= '0;
      mod_q   <= '0;
      din_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      row_q   <= row_d;
      lat_q   <= lat_d;
      mod_q   <= mod_d;
      din_q   <= din_d;
      cap_q   <= cap_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign s_ready       = (state_q == LOAD);
  assign ntt_mem_write = (state_q == WRITE);
  assign ntt_start     = (state_q == RUN);
  assign ntt_mem_read  = (state_q == READ) && (lat_q == '0);
  assign done          = (state_q == FIN);
  assign m_valid       = (state_q == DRAIN);
  assign m_last        = (state_q == DRAIN) && (lane_q == LANE_LAST) && (row_q == ROW_LAST);
  assign m_data        = (state_q == DRAIN) ? cap_q[lane_q*WIDTH +: WIDTH] : '0;
  assign ntt_mod_idx   = mod_q;
  assign ntt_din       = din_q;
  assign ntt_mem_addr  = {SIZE{row_q}};

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Randomized self-checking bench for ntt_stream_ctrl with a memory/core model
// and an expected-stream reference derived from row/lane arithmetic.
module tb_ntt_stream_ctrl;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 257;
  localparam int ROWS   = 2;
  localparam int RD_LAT = 2;
  localparam int N      = SIZE * ROWS;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cfg_start;
  logic [5:0]            cfg_mod_idx;
  logic                  busy;
  logic [WIDTH-1:0]      s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  ntt_start;
  logic [5:0]            ntt_mod_idx;
  logic                  ntt_mem_write;
  logic                  ntt_mem_read;
  logic [8*SIZE-1:0]     ntt_mem_addr;
  logic [WIDTH*SIZE-1:0] ntt_din;
  logic [WIDTH*SIZE-1:0] ntt_dout;
  logic                  ntt_done;
  logic                  done;

  ntt_stream_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .ROWS(ROWS), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_mod_idx(cfg_mod_idx),
    .busy(busy), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .ntt_start(ntt_start), .ntt_mod_idx(ntt_mod_idx), .ntt_mem_write(ntt_mem_write),
    .ntt_mem_read(ntt_mem_read), .ntt_mem_addr(ntt_mem_addr), .ntt_din(ntt_din),
    .ntt_dout(ntt_dout), .ntt_done(ntt_done), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] stream [N];
  bit               hv [RD_LAT+1];
  int               ha [RD_LAT+1];

  // Memory model: the row read RD_LAT cycles ago is valid now, garbage otherwise
  function automatic logic [WIDTH*SIZE-1:0] dout_row(input int r, input bit valid);
    logic [WIDTH*SIZE-1:0] v;
    for (int k = 0; k < SIZE; k++)
      v[k*WIDTH +: WIDTH] = valid ? WIDTH'(r * 1000 + k) : WIDTH'(32'hBAD00000 + k);
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_sready"}, s_ready, 0);
    check({tag, "_mvalid"}, m_valid, 0);
    check({tag, "_mlast"}, m_last, 0);
    check({tag, "_mdata"}, m_data, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_strobes"}, {ntt_start, ntt_mem_write, ntt_mem_read}, 0);
    check({tag, "_modidx"}, ntt_mod_idx, 0);
    check({tag, "_addr_zero"}, ntt_mem_addr == '0, 1);
    check({tag, "_din_zero"}, ntt_din == '0, 1);
  endtask

  task automatic run_job(input int mod, input bit gaps, input bit stall, input bit early,
                         input bit inject, input int abort_at, input bit seq_data);
    int sidx = 0, wr_cnt = 0, rd_cnt = 0, out_cnt = 0, start_c = -1, done_cnt = 0;
    bit injected = 0, fin = 0, aborted = 0, pv = 0, pr = 0;
    logic [WIDTH-1:0] pd = '0;
    for (int i = 0; i < N; i++) stream[i] = seq_data ? WIDTH'(i) : WIDTH'($urandom);
    for (int i = 0; i <= RD_LAT; i++) begin hv[i] = 0; ha[i] = 0; end
    for (int c = 0; c < 20000 && !fin && !aborted; c++) begin
      @(negedge clk);
      cfg_start   = (c == 0);
      cfg_mod_idx = (c == 0) ? 6'(mod) : 6'($urandom);
      if (c == 0) check("idle_before_start", busy, 0);
      if (inject && !injected && s_ready && sidx == 50) begin
        cfg_start = 1'b1; cfg_mod_idx = 6'd9; injected = 1;
      end
      s_valid  = gaps ? ($urandom % 3 != 0) : 1'b1;
      s_data   = (sidx < N) ? stream[sidx] : WIDTH'($urandom);
      m_ready  = stall ? 1'($urandom % 2) : 1'b1;
      ntt_done = early ? 1'b1 : (start_c >= 0 && c >= start_c + 10);
      for (int i = RD_LAT; i > 0; i--) begin hv[i] = hv[i-1]; ha[i] = ha[i-1]; end
      hv[0] = ntt_mem_read;
      ha[0] = int'(ntt_mem_addr[7:0]);
      ntt_dout = dout_row(ha[RD_LAT], hv[RD_LAT]);

      if (abort_at >= 0 && m_valid && out_cnt == abort_at) begin
        reset = 1'b1;
        #1;
        check_zero("abort");
        aborted = 1;
      end else begin
        if (s_valid && s_ready) sidx++;
        if (pv && !pr) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, pd);
        end
        if (ntt_start || ntt_mem_write || ntt_mem_read)
          check("strobe_excl", 32'(ntt_start) + 32'(ntt_mem_write) + 32'(ntt_mem_read), 1);
        if (ntt_mem_write) begin
          check("wr_after_row", sidx, (wr_cnt + 1) * SIZE);
          check("wr_addr_lo", ntt_mem_addr[7:0], wr_cnt);
          check("wr_addr_hi", ntt_mem_addr[8*SIZE-1 -: 8], wr_cnt);
          for (int k = 0; k < SIZE; k++)
            if (wr_cnt < ROWS)
              check("wr_lane", ntt_din[k*WIDTH +: WIDTH], stream[wr_cnt*SIZE + k]);
          wr_cnt++;
        end
        if (ntt_start) begin
          check("start_once", start_c, -1);
          check("start_rows", wr_cnt, ROWS);
          check("start_modidx", ntt_mod_idx, mod);
          start_c = c;
        end
        if (ntt_mem_read) begin
          if (rd_cnt == 0) check("rd_delay", c - start_c, early ? 3 : 11);
          check("rd_no_overlap", out_cnt, rd_cnt * SIZE);
          check("rd_addr_lo", ntt_mem_addr[7:0], rd_cnt);
          check("rd_addr_hi", ntt_mem_addr[8*SIZE-1 -: 8], rd_cnt);
          rd_cnt++;
        end
        if (m_valid && m_ready) begin
          check("m_data", m_data, (out_cnt / SIZE) * 1000 + (out_cnt % SIZE));
          check("m_last", m_last, out_cnt == N - 1);
          out_cnt++;
        end
        if (done) begin
          check("done_once", done_cnt, 0);
          check("done_after_drain", out_cnt, N);
          check("done_busy", busy, 1);
          done_cnt++;
          fin = 1;
        end
        pv = m_valid; pr = m_ready; pd = m_data;
      end
    end
    cfg_start = 1'b0;
    if (aborted) begin
      ntt_done = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        m_ready = 1'($urandom % 2);
        check("post_abort_busy", busy, 0);
        check("post_abort_strobes", {ntt_start, ntt_mem_write, ntt_mem_read, m_valid, s_ready, done}, 0);
      end
    end else if (fin) begin
      @(negedge clk);
      check("post_done_idle", {busy, done}, 0);
    end else begin
      check("job_timeout", fin, 1);
    end
  endtask

  initial begin
    reset = 1'b1; cfg_start = 1'b0; cfg_mod_idx = '0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; ntt_done = 1'b0; ntt_dout = '0;
    #2;
    check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // mod, gaps, stall, early_done, inject_start, abort_at, sequential data
    run_job(5,  0, 0, 0, 0, -1, 1);
    run_job(17, 1, 1, 1, 1, -1, 0);
    run_job(33, 1, 1, 0, 0, 100, 0);
    run_job(5,  1, 1, 0, 0, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
